// File: rtl/adc_scan.sv
// -----------------------------------------------------------------------------
// adc_scan
//   Behavioural multi-channel scanning ADC. A start pulse converts every analog
//   input in turn, from channel 0 up to CHANNELS-1. Each result is held on the
//   output port until the consumer takes it with a valid/ready handshake.
//
//   Optional feature (macro ADC_SCAN_AVG_EN):
//     When defined, SAMPLE takes four consecutive samples of the current
//     channel and converts their mean. The result latency grows by three edges.
//     When undefined, no averaging logic is built.
//
//   Parameters:
//     BITS        output code width (2..16)
//     CHANNELS    number of analog inputs (1..16)
//     VREF        full-scale reference voltage
//     CONV_CYCLES conversion edges per sample (>=1)
//
//   Ports:
//     clk        single clock, rising edge
//     rst        asynchronous active-low reset
//     start      request one scan of all channels (seen only in IDLE)
//     in         analog inputs in volts, one per channel
//     out        conversion code
//     out_ch     channel index of out
//     out_valid  out/out_ch/ovr valid
//     out_ready  consumer accepts the presented result
//     busy       scan in progress
//     ovr        result was clamped or the input was NaN/infinite
// -----------------------------------------------------------------------------
module adc_scan #(
  parameter int  BITS        = 8,
  parameter int  CHANNELS    = 4,
  parameter real VREF        = 1.0,
  parameter int  CONV_CYCLES = 3
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  real                                                    in [CHANNELS],
  output logic [BITS-1:0]                                        out,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]     out_ch,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   busy,
  output logic                                                   ovr
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW   = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int FULL = 1 << BITS;

  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
  localparam logic [NW-1:0] LAST_CNT = NW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, HOLD} state_t;

  state_t         state;
  logic [CW-1:0]  ch;
  logic [NW-1:0]  cnt;
  real            held;

`ifdef ADC_SCAN_AVG_EN
  real            acc;
  logic [1:0]     avg_cnt;
`endif

  // Maps a voltage to {ovr, code}. NaN and +/-inf are caught first: for any
  // finite v, v - v is exactly 0.0, while for NaN or infinity it is NaN, and
  // NaN compares unequal to everything. The final clamp guards against the
  // scaled value rounding up to 2^BITS for inputs just below VREF.
  function automatic logic [BITS:0] quantize(input real v);
    real          scaled;
    int           raw;
    logic [BITS:0] res;
    res    = '0;
    scaled = 0.0;
    raw    = 0;
    if ((v - v) != 0.0) begin
      res = {1'b1, {BITS{1'b0}}};
    end else if (v < 0.0) begin
      res = {1'b1, {BITS{1'b0}}};
    end else if (v >= VREF) begin
      res = {1'b1, {BITS{1'b1}}};
    end else begin
      scaled = v / VREF * $itor(FULL);
      raw    = $rtoi(scaled);
      if (raw >= FULL) begin
        res = {1'b0, {BITS{1'b1}}};
      end else begin
        res = {1'b0, raw[BITS-1:0]};
      end
    end
    return res;
  endfunction

  // Scan sequencer. All outputs are registered here. Only SAMPLE reads the
  // analog inputs, so input changes in CONVERT or HOLD cannot disturb the
  // result in flight. On a handshake, out/out_ch/ovr keep their last values.
  // Only out_valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ch        <= '0;
      cnt       <= '0;
      held      <= 0.0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc       <= 0.0;
      avg_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SAMPLE;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
`ifdef ADC_SCAN_AVG_EN
          // A NaN or infinite sample propagates into the mean as NaN or inf.
          // quantize() then flags it without a separate sticky bit.
          if (avg_cnt == 2'd3) begin
            held    <= (acc + in[ch]) / 4.0;
            acc     <= 0.0;
            avg_cnt <= '0;
            cnt     <= '0;
            state   <= CONVERT;
          end else begin
            acc     <= acc + in[ch];
            avg_cnt <= avg_cnt + 2'd1;
          end
`else
          held  <= in[ch];
          cnt   <= '0;
          state <= CONVERT;
`endif
        end
        CONVERT: begin
          if (cnt == LAST_CNT) begin
            {ovr, out} <= quantize(held);
            out_ch     <= ch;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ch == LAST_CH) begin
              ch    <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              ch    <= ch + 1'b1;
              state <= SAMPLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan.sv
// -----------------------------------------------------------------------------
// tb_adc_scan
//   Self-checking bench for adc_scan with default parameters. A table of
//   {input voltage, expected code, expected ovr} records drives whole scans.
//   Hand-written sequences cover the HOLD back-pressure case, the mid-scan
//   reset case and, when ADC_SCAN_AVG_EN is defined, averaging.
// -----------------------------------------------------------------------------
module tb_adc_scan;

`ifdef ADC_SCAN_AVG_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  typedef struct packed {
    logic [63:0] vbits;
    logic [7:0]  code;
    logic        ovr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  real        ain [4];
  logic [7:0] out;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       ovr;

  vec_t tbl [16];
  int   checks;
  int   failures;

  adc_scan dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (ain),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovr       (ovr)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Load four table entries onto the inputs and pulse start. The task
  // returns #1 after the edge that accepts start.
  task automatic applyStimulus(input int base, input logic ready, input logic fromReset);
    for (int i = 0; i < 4; i++) ain[i] = $bitstoreal(tbl[base+i].vbits);
    @(negedge clk);
    out_ready = ready;
    start     = 1'b1;
    if (fromReset) rst = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
  endtask

  // Count edges until a result appears, then compare it against the table.
  task automatic waitResult(input int idx, input int chan);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    checkOutput($sformatf("latency_ch%0d", chan), n, LAT);
    checkOutput($sformatf("code_ch%0d", chan), int'(out), int'(tbl[idx].code));
    checkOutput($sformatf("outch_ch%0d", chan), int'(out_ch), chan);
    checkOutput($sformatf("ovr_ch%0d", chan), int'(ovr), int'(tbl[idx].ovr));
  endtask

  task automatic handshakeEdge();
    @(posedge clk);
    #1;
    checkOutput("valid_after_handshake", int'(out_valid), 0);
  endtask

  task automatic runScan(input int base);
    applyStimulus(base, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      waitResult(base + c, c);
      handshakeEdge();
    end
    checkOutput("busy_after_scan", int'(busy), 0);
  endtask

  initial begin
    int  seen;
    int  n;
    real avgVals [4];

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) ain[i] = 0.0;

    tbl[0]  = '{$realtobits(0.5),        8'd128, 1'b0};
    tbl[1]  = '{$realtobits(0.0),        8'd0,   1'b0};
    tbl[2]  = '{$realtobits(0.999),      8'd255, 1'b0};
    tbl[3]  = '{$realtobits(0.25),       8'd64,  1'b0};
    tbl[4]  = '{$realtobits(-0.3),       8'd0,   1'b1};
    tbl[5]  = '{$realtobits(1.7),        8'd255, 1'b1};
    tbl[6]  = '{64'h7FF8000000000000,    8'd0,   1'b1};
    tbl[7]  = '{$realtobits(1.0),        8'd255, 1'b1};
    tbl[8]  = '{$realtobits(0.00390625), 8'd1,   1'b0};
    tbl[9]  = '{$realtobits(0.99609375), 8'd255, 1'b0};
    tbl[10] = '{64'h7FF0000000000000,    8'd0,   1'b1};
    tbl[11] = '{$realtobits(0.7),        8'd179, 1'b0};
    tbl[12] = '{$realtobits(0.25),       8'd64,  1'b0};
    tbl[13] = '{$realtobits(0.5),        8'd128, 1'b0};
    tbl[14] = '{$realtobits(0.75),       8'd192, 1'b0};
    tbl[15] = '{$realtobits(0.125),      8'd32,  1'b0};

    // Reset values
    #2 rst = 1'b0;
    #10;
    checkOutput("reset_out", int'(out), 0);
    checkOutput("reset_out_ch", int'(out_ch), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ovr", int'(ovr), 0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven scans: nominal, out-of-range/NaN, boundaries and infinity
    runScan(0);
    runScan(4);
    runScan(8);

    // Back-pressure in HOLD with input changes and ignored start pulses
    applyStimulus(12, 1'b0, 1'b0);
    waitResult(12, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ain[0] = 0.9 - 0.05 * k;
      start  = ~start;
      @(posedge clk);
      #1;
      checkOutput("hold_code", int'(out), 64);
      checkOutput("hold_out_ch", int'(out_ch), 0);
      checkOutput("hold_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    handshakeEdge();
    for (int c = 1; c < 4; c++) begin
      waitResult(12 + c, c);
      handshakeEdge();
    end
    checkOutput("hold_busy_end", int'(busy), 0);

    // Asynchronous reset during CONVERT of channel 2
    applyStimulus(8, 1'b1, 1'b0);
    waitResult(8, 0);
    handshakeEdge();
    waitResult(9, 1);
    handshakeEdge();
    @(posedge clk);
    @(posedge clk);
    #3;
    checkOutput("pre_reset_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("midreset_out", int'(out), 0);
    checkOutput("midreset_out_ch", int'(out_ch), 0);
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_ovr", int'(ovr), 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("no_partial_result", seen, 0);
    checkOutput("idle_after_abort", int'(busy), 0);

    // Start on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      waitResult(c, c);
      handshakeEdge();
    end
    checkOutput("restart_busy_end", int'(busy), 0);

`ifdef ADC_SCAN_AVG_EN
    // Averaging: 0.2, 0.4, 0.6 and 0.8 on channel 0 average to 0.5
    avgVals = '{0.2, 0.4, 0.6, 0.8};
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    ain[0] = avgVals[0];
    n      = 0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      n++;
      ain[0] = avgVals[k];
    end
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    checkOutput("avg_latency", n, 7);
    checkOutput("avg_code", int'(out), 128);
    checkOutput("avg_ovr", int'(ovr), 0);
    checkOutput("avg_out_ch", int'(out_ch), 0);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
`else
    avgVals = '{0.0, 0.0, 0.0, 0.0};
    n       = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_scan.md
ADC_SCAN -- requirements
Module: adc_scan

Interface
REQ-001 SHALL have parameter BITS, default 8, output code width (2..16).
REQ-002 SHALL have parameter CHANNELS, default 4, number of real analog inputs (1..16).
REQ-003 SHALL have parameter real VREF, default 1.0, full-scale reference voltage.
REQ-004 SHALL have parameter CONV_CYCLES, default 3, conversion cycles per sample (>=1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request one full scan of all channels.
REQ-008 in  input  real[CHANNELS]  analog inputs, volts.
REQ-009 out  output  BITS  conversion code.
REQ-010 out_ch  output  max(1,$clog2(CHANNELS))  channel index of out.
REQ-011 out_valid  output  1  out/out_ch/ovr valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 busy  output  1  scan in progress.
REQ-014 ovr  output  1  current result was clamped or invalid.

Function
REQ-015 SHALL implement FSM IDLE, SAMPLE, CONVERT, HOLD.
REQ-016 IDLE: start=1 at an edge -> SAMPLE with channel counter=0; start ignored in all other states.
REQ-017 SAMPLE: captures in[ch] into internal real register, -> CONVERT next edge.
REQ-018 CONVERT: counts CONV_CYCLES edges, then -> HOLD with out, out_ch, ovr loaded and out_valid=1.
REQ-019 out_valid SHALL rise exactly CONV_CYCLES+1 edges after the edge accepting start (first channel) or accepting the previous handshake (later channels).
REQ-020 HOLD: out, out_ch, ovr, out_valid SHALL stay stable until out_valid&&out_ready at an edge.
REQ-021 On handshake: ch<CHANNELS-1 -> ch+1, SAMPLE; ch==CHANNELS-1 -> ch=0, IDLE, out_valid=0.
REQ-022 busy SHALL be 1 in SAMPLE, CONVERT, HOLD; 0 in IDLE.
REQ-023 Quantisation: code=floor(v/VREF*2^BITS) for 0.0<=v<VREF, ovr=0.
REQ-024 v<0.0 -> code 0, ovr=1; v>=VREF -> code all-ones, ovr=1.
REQ-025 v NaN or +/-infinity -> code 0, ovr=1.
REQ-026 Monotonic: for valid inputs v1<v2 code(v1)<=code(v2), and code difference <=1 when v2-v1<=VREF/2^BITS.
REQ-027 Input changes outside SAMPLE SHALL NOT affect the in-flight result.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, ch=0, counter=0, out=0, out_ch=0, out_valid=0, busy=0, ovr=0, held sample=0.0.
REQ-029 Reset mid-scan SHALL abandon the scan; no partial result presented after release.
REQ-030 First edge after rst release SHALL accept start normally.

Configuration
REQ-031 Macro ADC_SCAN_AVG_EN SHALL select averaging in SAMPLE.
REQ-032 Defined: SAMPLE lasts 4 edges, captures 4 consecutive in[ch] values, converts their arithmetic mean; out_valid latency becomes CONV_CYCLES+4; ovr set if mean out of range or any sample NaN/inf.
REQ-033 Undefined: single-sample SAMPLE per REQ-017, no averaging logic present.

Verification
REQ-034 in={0.5,0.0,0.999,0.25}, start pulse, out_ready=1 -> codes 128,0,255,64 on out_ch 0..3, ovr=0, busy falls after 4th handshake.
REQ-035 start at edge t, out_ready=1 -> first out_valid at edge t+4 (default parameters, no AVG_EN).
REQ-036 in[0]=-0.3, in[1]=1.7, in[2]=NaN -> codes 0,255,0 with ovr=1 each.
REQ-037 out_ready=0 for 10 cycles in HOLD while in changes -> out, out_ch, out_valid unchanged; start pulses ignored.
REQ-038 rst=0 asynchronously mid-CONVERT of channel 2 -> all outputs 0 same cycle; after release start -> scan restarts at out_ch 0.
REQ-039 ADC_SCAN_AVG_EN, in[0] sequence 0.2,0.4,0.6,0.8 during SAMPLE -> code 128, first out_valid at edge t+7.
